// File: rtl/cache_arbiter.sv
// ============================================================================
// Module   : cache_arbiter
// Brief    : Round-robin arbiter sharing one memory port between I$ and D$.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cache_arbiter #(
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  icache_pmem_read,
    input  logic [31:0]           icache_pmem_address,
    output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
    output logic                  icache_pmem_resp,

    input  logic                  dcache_pmem_read,
    input  logic                  dcache_pmem_write,
    input  logic [31:0]           dcache_pmem_address,
    input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
    output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
    output logic                  dcache_pmem_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [31:0]           mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_SERVE = 2'd1,
        D_SERVE = 2'd2
    } state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t                  state_q;
    logic                    last_grant_q;
    logic [31:0]             addr_q;
    logic [LINE_WIDTH-1:0]   wdata_q;
    logic                    read_q;
    logic                    write_q;

    logic                    w_d_req;
    logic                    w_pick_d;

    // On contention the cache that did not win last time goes first.
    assign w_d_req  = dcache_pmem_read | dcache_pmem_write;
    assign w_pick_d = w_d_req & (~icache_pmem_read | (last_grant_q == GRANT_I));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_pick_d) begin
                        state_q      <= D_SERVE;
                        last_grant_q <= GRANT_D;
                        addr_q       <= dcache_pmem_address;
                        wdata_q      <= dcache_pmem_wdata;
                        // A simultaneous read+write is treated as a writeback.
                        write_q      <= dcache_pmem_write;
                        read_q       <= ~dcache_pmem_write;
                    end else if (icache_pmem_read) begin
                        state_q      <= I_SERVE;
                        last_grant_q <= GRANT_I;
                        addr_q       <= icache_pmem_address;
                        read_q       <= 1'b1;
                        write_q      <= 1'b0;
                    end
                end
                I_SERVE, D_SERVE: begin
                    if (mem_resp) begin
                        state_q <= IDLE;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read          = read_q;
    assign mem_write         = write_q;
    assign mem_address       = addr_q;
    assign mem_wdata         = wdata_q;

    assign icache_pmem_rdata = mem_rdata;
    assign dcache_pmem_rdata = mem_rdata;
    assign icache_pmem_resp  = (state_q == I_SERVE) & mem_resp;
    assign dcache_pmem_resp  = (state_q == D_SERVE) & mem_resp;

endmodule

`default_nettype wire

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_WIDTH, default 256, giving the cache line / memory burst data width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port icache_pmem_read, input, 1, instruction cache line-fill request.
REQ-005 The block SHALL have port icache_pmem_address, input, 32, instruction cache line address.
REQ-006 The block SHALL have port icache_pmem_rdata, output, LINE_WIDTH, returned line to the instruction cache.
REQ-007 The block SHALL have port icache_pmem_resp, output, 1, one-cycle completion pulse to the instruction cache.
REQ-008 The block SHALL have ports dcache_pmem_read and dcache_pmem_write, input, 1 each, data cache fill and writeback requests.
REQ-009 The block SHALL have port dcache_pmem_address, input, 32, and port dcache_pmem_wdata, input, LINE_WIDTH, data cache address and writeback line.
REQ-010 The block SHALL have port dcache_pmem_rdata, output, LINE_WIDTH, and port dcache_pmem_resp, output, 1, returned line and completion pulse to the data cache.
REQ-011 The block SHALL have ports mem_read and mem_write, output, 1 each, plus mem_address, output, 32, and mem_wdata, output, LINE_WIDTH, the request to the shared memory / cacheline adaptor.
REQ-012 The block SHALL have port mem_rdata, input, LINE_WIDTH, and port mem_resp, input, 1, the memory return data and one-cycle completion pulse.

Function
REQ-013 FSM states SHALL be IDLE, I_SERVE, and D_SERVE, plus a 1-bit last_grant register (I or D).
REQ-014 In IDLE with only an icache request, the next state SHALL be I_SERVE; with only a dcache request (read or write), it SHALL be D_SERVE; with no request, it SHALL stay IDLE.
REQ-015 In IDLE with both requesting, the grant SHALL go to the requester not equal to last_grant (round-robin); last_grant SHALL update on every grant.
REQ-016 On the IDLE-to-serve transition, the block SHALL latch the granted address, operation, and wdata (dcache only) into internal registers; mem_* outputs SHALL be driven from these latches for the entire serve state.
REQ-017 Latency: a request sampled in IDLE at edge N SHALL have mem_read or mem_write asserted during cycle N+1.
REQ-018 In a serve state, mem_read or mem_write SHALL remain asserted until and including the cycle mem_resp=1; exactly one of them SHALL be high.
REQ-019 If mem_resp=1 in a serve state, the block SHALL pass it combinationally that cycle to the served cache's *_pmem_resp and SHALL set the next state to IDLE.
REQ-020 mem_rdata SHALL be routed to both icache_pmem_rdata and dcache_pmem_rdata at all times; only the resp pulse qualifies it.
REQ-021 The non-served cache's resp SHALL be 0 at all times; both resp outputs SHALL be 0 in IDLE.
REQ-022 mem_resp while in IDLE SHALL be ignored, with no output change.
REQ-023 After each completion, the block SHALL spend at least one IDLE cycle before the next grant, so that the finished cache can drop its request.
REQ-024 If dcache_pmem_read and dcache_pmem_write are both high at grant, the operation SHALL be latched as a write.
REQ-025 A requester deasserting mid-transaction SHALL NOT abort the transaction; it SHALL still complete and issue a resp.
REQ-026 In IDLE, mem_read=mem_write=0; mem_address and mem_wdata SHALL hold their last latched values.

Reset
REQ-027 With rst=1 at an edge, the block SHALL set the state to IDLE, last_grant to I, and the latched address and wdata to 0, with all request and resp outputs 0 the following cycle; this SHALL hold even mid-transaction.
REQ-028 A mem_resp arriving after a mid-transaction reset SHALL be dropped per REQ-022.

Verification
REQ-029 Icache-only scenario: a read of 0x0000_0060 with mem_resp after 3 cycles SHALL give mem_read=1 and mem_address=0x60 from the next cycle, and icache_pmem_resp=1 with rdata=mem_rdata in the resp cycle.
REQ-030 Simultaneous scenario: icache read 0x100 and dcache write 0x200 in IDLE after reset SHALL be served dcache first (last_grant=I, mem_write=1, wdata forwarded), then icache after one IDLE cycle.
REQ-031 Back-to-back dcache scenario: dcache reads 0x40 then 0x80 while icache requests constantly SHALL produce the order D(0x40), I, D(0x80).
REQ-032 Dropped-request scenario: dcache read 0x300 deasserted one cycle after grant SHALL keep mem_read=1 and mem_address=0x300 until mem_resp, then pulse dcache_pmem_resp.
REQ-033 Reset scenario: rst asserted during I_SERVE SHALL bring mem_read to 0 the next cycle, ignore a subsequent stale mem_resp, and have both resp outputs stay 0.
